truth_table_sweeper: RTL



---
 rtl/truth_pkg.sv | 23 ++
 rtl/sweep_index_gen.sv | 43 ++++
 rtl/truth_table_sweeper.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/truth_pkg.sv
// Shared encodings for the truth-table sweeper: FSM state codes and
// expected truth tables for the reference expressions (N_IN = 3).
package truth_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } sweep_state_t;

    // Bit i of each table is f evaluated at {x,y,z} == i.
    localparam logic [7:0] EXP_NOR_NZ = 8'h01;
    localparam logic [7:0] EXP_NOT_Z  = 8'h55;
    localparam logic [7:0] EXP_ZERO   = 8'h00;
    localparam logic [7:0] EXP_ONE    = 8'hFF;

endpackage

// File: rtl/sweep_index_gen.sv
// Step counter for the sweep; maps step to the driven vector.
// Build option: define SWEEP_GRAY_EN for Gray-code visit order (binary otherwise).
module sweep_index_gen #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [N_IN-1:0] vec_o,
    output logic            last_o
);

    logic [N_IN-1:0] step_q;
    logic [N_IN-1:0] step_d;

    always_comb begin
        step_d = step_q;
        if (clear_i) begin
            step_d = '0;
        end else if (advance_i) begin
            step_d = step_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

`ifdef SWEEP_GRAY_EN
    // Gray order toggles exactly one input of the expression per step.
    assign vec_o = step_q ^ (step_q >> 1);
`else
    assign vec_o = step_q;
`endif

    assign last_o = &step_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all input combinations into a combinational expression, captures its
// truth table and compares it with EXPECTED. Build option: SWEEP_GRAY_EN (see sweep_index_gen).
module truth_table_sweeper
    import truth_pkg::*;
#(
    parameter int                   N_IN     = 3,
    parameter int                   SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0] EXPECTED = EXP_NOR_NZ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        mismatch_idx
);

    localparam int         NV       = 2 ** N_IN;
    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    sweep_state_t    state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NV-1:0]   table_q, table_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] midx_q, midx_d;
    logic            first_q, first_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            clearIdx;
    logic            advanceIdx;
    logic [N_IN-1:0] vec;
    logic            lastStep;

    sweep_index_gen #(.N_IN(N_IN)) u_index (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (clearIdx),
        .advance_i (advanceIdx),
        .vec_o     (vec),
        .last_o    (lastStep)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        table_d    = table_q;
        err_d      = err_q;
        midx_d     = midx_q;
        first_d    = first_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        clearIdx   = 1'b0;
        advanceIdx = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WAIT;
                    cnt_d    = SETTLE_C;
                    table_d  = '0;
                    err_d    = '0;
                    midx_d   = '0;
                    first_d  = 1'b0;
                    pass_d   = 1'b0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    clearIdx = 1'b1;
                end else if (state_q == S_DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_q == '0);
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                table_d[vec] = f_in;
                // Four-state compare so an undriven or X response is a mismatch.
                if (f_in !== EXPECTED[vec]) begin
                    err_d = err_q + 1'b1;
                    if (!first_q) begin
                        midx_d  = vec;
                        first_d = 1'b1;
                    end
                end
                if (lastStep) begin
                    state_d = S_DONE;
                end else begin
                    advanceIdx = 1'b1;
                    cnt_d      = SETTLE_C;
                    state_d    = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            table_q <= '0;
            err_q   <= '0;
            midx_q  <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            err_q   <= err_d;
            midx_q  <= midx_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out      = vec;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign table_out    = table_q;
    assign err_count    = err_q;
    assign mismatch_idx = midx_q;

endmodule
